// File: rtl/shift_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// shift_req_arbiter_if
//   Bundles the two request channels and the response channel of the
//   shared-shifter arbiter.
//
//   Handshake rule (all three channels): a transfer happens on a rising clock
//   edge where valid && ready. The source holds valid and its payload
//   unchanged until that edge. The sink may raise ready independently of
//   valid. It may also raise ready combinationally from valid, which the
//   arbiter does for req0_ready/req1_ready.
//
//   Signals
//     req0_valid/data/amt, req0_ready  requester 0 channel
//     req1_valid/data/amt, req1_ready  requester 1 channel
//     rsp_valid/data/id,  rsp_ready    response channel (id = owning requester)
//
//   Modports
//     master : requesters + response consumer (testbench / system side)
//     slave  : the arbiter
// ---------------------------------------------------------------------------
interface shift_req_arbiter_if #(
    parameter int AMT_W = 3
);
    logic             req0_valid;
    logic [3:0]       req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_ready;

    logic             req1_valid;
    logic [3:0]       req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_ready;

    logic             rsp_valid;
    logic [3:0]       rsp_data;
    logic             rsp_id;
    logic             rsp_ready;

    modport master (
        output req0_valid, req0_data, req0_amt,
        input  req0_ready,
        output req1_valid, req1_data, req1_amt,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt,
        output req0_ready,
        input  req1_valid, req1_data, req1_amt,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/shift_req_arbiter.sv
// ---------------------------------------------------------------------------
// barrel_shifter_4bit
//   Combinational 4-bit logical left shift by 0..3, zero fill.
//   Ports: a (operand), shift_amt (0..3), y (result).
//
// shift_req_arbiter
//   Round-robin arbiter sharing one barrel_shifter_4bit between two
//   requesters. Shift amounts above 3 are executed as several passes of at
//   most 3 bits, with the running result kept in acc. Results return on the
//   response channel tagged with the requester id.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     bus         request/response channels (slave side)
//     busy        high whenever the FSM is not IDLE
//     dbg_state   current FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
// ---------------------------------------------------------------------------
module barrel_shifter_4bit (
    input  logic [3:0] a,
    input  logic [1:0] shift_amt,
    output logic [3:0] y
);
    assign y = a << shift_amt;
endmodule

module shift_req_arbiter #(
    parameter int AMT_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_req_arbiter_if.slave      bus,
    output logic                    busy,
    output logic [1:0]              dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [3:0]       acc;
    logic [AMT_W-1:0] rem;
    logic             id;
    logic             rr;          // 0: req0 wins a tie, 1: req1 wins a tie

    logic             gnt_valid;
    logic             gnt_id;
    logic             accept;
    logic [1:0]       step;
    logic [AMT_W-1:0] rem_next;
    logic [3:0]       shift_y;

    // Grant selection: the pointer only matters when both requesters are valid.
    always_comb begin
        gnt_valid = bus.req0_valid | bus.req1_valid;
        gnt_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_id = rr;
        end else begin
            gnt_id = bus.req1_valid;
        end
    end

    assign accept         = (state == IDLE) && gnt_valid;
    assign bus.req0_ready = accept && !gnt_id;
    assign bus.req1_ready = accept &&  gnt_id;

    // Each pass shifts by at most 3; step never exceeds rem, so rem cannot wrap.
    always_comb begin
        step = rem[1:0];
        if (rem > AMT_W'(3)) begin
            step = 2'd3;
        end
    end

    assign rem_next = rem - AMT_W'(step);

    barrel_shifter_4bit u_shifter (
        .a         (acc),
        .shift_amt (step),
        .y         (shift_y)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)          state_next = SHIFT;
            SHIFT:   if (rem_next == '0)  state_next = DONE;
            DONE:    if (bus.rsp_ready)   state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            id    <= 1'b0;
            rr    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= gnt_id ? bus.req1_data : bus.req0_data;
                        rem <= gnt_id ? bus.req1_amt  : bus.req0_amt;
                        id  <= gnt_id;
                        rr  <= ~gnt_id;
                    end
                end
                SHIFT: begin
                    acc <= shift_y;
                    rem <= rem_next;
                end
                default: ;
            endcase
        end
    end

    // Response payload is forced to zero outside DONE so idle outputs are clean.
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_data  = (state == DONE) ? acc : 4'd0;
    assign bus.rsp_id    = (state == DONE) ? id  : 1'b0;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;
endmodule

// File: tb/tb_shift_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_req_arbiter
//   Directed bench for shift_req_arbiter. Expected {id,data} pairs are pushed
//   to exp_q at the accept edge and popped when the response is taken.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_shift_req_arbiter;
    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] dbg_state;

    int n_checks;
    int n_fail;
    logic [4:0] exp_q[$];

    shift_req_arbiter_if #(.AMT_W(3)) bus ();

    shift_req_arbiter #(.AMT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker / model ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int passes(input int amt);
        return (amt == 0) ? 1 : (amt + 2) / 3;
    endfunction

    function automatic logic [3:0] model(input logic [3:0] d, input int amt);
        logic [15:0] t;
        t = {12'd0, d} << amt;
        return t[3:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge. Returns 1 ns after the accept edge.
    task automatic send(input bit rid, input logic [3:0] d, input logic [2:0] amt);
        int k;
        if (rid) begin
            bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_amt = amt;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_amt = amt;
        end
        #1;
        k = 0;
        while (!(rid ? bus.req1_ready : bus.req0_ready) && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        chk("accept_timeout", 32'(k < 20), 32'd1);
        chk("two_readys", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        exp_q.push_back({rid, model(d, int'(amt))});
        @(posedge clk); #1;
        if (rid) bus.req1_valid = 1'b0;
        else     bus.req0_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.rsp_valid) break;
            chk("busy_in_shift", 32'(busy), 32'd1);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    // Holds rsp_ready low for 'hold' cycles, then takes the response.
    task automatic take_rsp(input int hold);
        logic [4:0] first;
        logic [4:0] exp;
        first = {bus.rsp_id, bus.rsp_data};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_stable", 32'({bus.rsp_id, bus.rsp_data}), 32'(first));
            chk("ready_while_busy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1f;
        chk("rsp_id_data", 32'({bus.rsp_id, bus.rsp_data}), 32'(exp));
        bus.rsp_ready = 1'b1;
        #1;
        chk("no_accept_on_rsp", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_amt = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0;
        bus.rsp_ready  = 1'b0;
        do_reset();

        // Reset state
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // amt 0: single identity pass
        send(1'b0, 4'b1011, 3'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_rsp(1);
        take_rsp(0);

        // single-pass shifts
        send(1'b1, 4'b0001, 3'd3); wait_rsp(1); take_rsp(0);
        send(1'b0, 4'b0011, 3'd2); wait_rsp(1); take_rsp(0);

        // amt 7: passes 3,3,1
        send(1'b0, 4'b0001, 3'd7); wait_rsp(3); take_rsp(0);

        // random single-requester traffic
        for (int i = 0; i < 8; i++) begin
            bit         rid;
            logic [3:0] d;
            logic [2:0] a;
            rid = 1'($urandom_range(0, 1));
            d   = 4'($urandom_range(0, 15));
            a   = 3'($urandom_range(0, 7));
            send(rid, d, a);
            wait_rsp(passes(int'(a)));
            take_rsp(0);
        end

        // Backpressure in DONE with req1 waiting
        send(1'b0, 4'b0110, 3'd1);
        wait_rsp(1);
        bus.req1_valid = 1'b1; bus.req1_data = 4'b1001; bus.req1_amt = 3'd5;
        take_rsp(5);
        send(1'b1, 4'b1001, 3'd5); wait_rsp(2); take_rsp(0);

        // Both valid after reset: strict alternation starting at req0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] d0;
            logic [3:0] d1;
            bit         g;
            d0 = 4'(i + 1);
            d1 = 4'(i + 5);
            bus.req0_valid = 1'b1; bus.req0_data = d0; bus.req0_amt = 3'd1;
            bus.req1_valid = 1'b1; bus.req1_data = d1; bus.req1_amt = 3'd4;
            #1;
            g = (i % 2 == 1);
            chk("rr_req0_ready", 32'(bus.req0_ready), 32'(!g));
            chk("rr_req1_ready", 32'(bus.req1_ready), 32'(g));
            exp_q.push_back({g, g ? model(d1, 4) : model(d0, 1)});
            @(posedge clk); #1;
            wait_rsp(g ? 2 : 1);
            take_rsp(0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset during SHIFT of an amt7 request aborts it
        @(negedge clk);
        send(1'b0, 4'b0001, 3'd7);
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("pre_rst_state", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_state", 32'(dbg_state), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rsp_after_abort", 32'(bus.rsp_valid), 32'd0);
        end
        bus.req0_valid = 1'b1; bus.req0_data = 4'b0101; bus.req0_amt = 3'd2;
        bus.req1_valid = 1'b1; bus.req1_data = 4'b0011; bus.req1_amt = 3'd1;
        #1;
        chk("ptr_reset_req0", 32'(bus.req0_ready), 32'd1);
        chk("ptr_reset_req1", 32'(bus.req1_ready), 32'd0);
        exp_q.push_back({1'b0, model(4'b0101, 2)});
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_rsp(1);
        take_rsp(0);
        send(1'b1, 4'b0011, 3'd1); wait_rsp(1); take_rsp(0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end
endmodule
